// File: rtl/core_run_ctrl.sv
// Run sequencer for the processor core: holds the core in reset, issues a one-cycle req,
// counts RUN cycles until done or a cycle limit, then presents the result to the host.
module core_run_ctrl #(
    parameter int CW         = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 4000,
    parameter int RW         = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          ack,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          result_valid,
    output logic          timeout,
    output logic [CW-1:0] cycle_count,
    output logic [RW-1:0] run_count
);

    localparam int RCW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CRST = 3'd1,
        REQ  = 3'd2,
        RUN  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cyc;
    logic           run_done;
    logic           run_tmo;

    // abort outranks both completion causes; done outranks the limit.
    assign run_done = (state == RUN) && !abort && core_done;
    assign run_tmo  = (state == RUN) && !abort && !core_done && (cyc == CW'(MAX_CYCLES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CRST;
            CRST: begin
                if (abort)                      state_nxt = IDLE;
                else if (rst_cnt <= RCW'(1))    state_nxt = REQ;
            end
            REQ:  state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                      state_nxt = IDLE;
                else if (run_done || run_tmo)   state_nxt = FIN;
            end
            FIN:  if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            cyc         <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            run_count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) rst_cnt <= RCW'(RST_CYCLES);
                CRST: rst_cnt <= rst_cnt - RCW'(1);
                REQ:  cyc <= CW'(1);
                RUN: begin
                    if (run_done) begin
                        cycle_count <= cyc;
                        timeout     <= 1'b0;
                        run_count   <= run_count + RW'(1);
                    end else if (run_tmo) begin
                        cycle_count <= CW'(MAX_CYCLES);
                        timeout     <= 1'b1;
                        run_count   <= run_count + RW'(1);
                    end else if (!abort) begin
                        cyc <= cyc + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Core stays released in FIN so its state can still be inspected.
    assign core_reset   = (state == IDLE) || (state == CRST);
    assign core_req     = (state == REQ);
    assign busy         = (state == CRST) || (state == REQ) || (state == RUN);
    assign result_valid = (state == FIN);

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a vector table, directed corner sequences and randomized runs
// checked against a per-run outcome model.
module tb_core_run_ctrl;

    localparam int CW = 16, RSTC = 2, MAXC = 20, RW = 8;

    logic          clk, reset, start, abort, ack, core_done;
    logic          core_reset, core_req, busy, result_valid, timeout;
    logic [CW-1:0] cycle_count;
    logic [RW-1:0] run_count;

    core_run_ctrl #(.CW(CW), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .core_done(core_done), .core_reset(core_reset), .core_req(core_req),
        .busy(busy), .result_valid(result_valid), .timeout(timeout),
        .cycle_count(cycle_count), .run_count(run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int exp_cc = 0, exp_to = 0, exp_rc = 0;

    typedef struct {
        logic       st, ab, ak, dn;
        logic [3:0] es;          // {core_reset, core_req, busy, result_valid}
        logic       eto;
        int         ecc, erc;
    } vec_t;
    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string nm, input logic [3:0] e);
        chk(nm, 32'({core_reset, core_req, busy, result_valid}), 32'(e));
    endtask

    task automatic chk_res(input string nm);
        chk({nm, " cycle_count"}, 32'(cycle_count), exp_cc);
        chk({nm, " timeout"}, 32'(timeout), exp_to);
        chk({nm, " run_count"}, 32'(run_count), exp_rc);
    endtask

    task automatic add(input logic st, ab, ak, dn, input logic [3:0] es,
                       input logic eto, input int ecc, erc);
        vec_t v;
        v.st = st; v.ab = ab; v.ak = ak; v.dn = dn;
        v.es = es; v.eto = eto; v.ecc = ecc; v.erc = erc;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; ack = 1'b0; core_done = 1'b0;
    endtask

    // One launch from IDLE. done_at / abort_at name the RUN cycle (1-based) the
    // event is raised in; 0 means never. Outcome follows abort > done > limit.
    task automatic do_run(input int done_at, input int abort_at, input bit noisy);
        bit ended;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < RSTC; k++) begin
            chk_st("crst", 4'b1010);
            core_done = noisy ? 1'($urandom) : 1'b0;
            tick();
        end
        chk_st("req", 4'b0110);
        core_done = noisy ? 1'($urandom) : 1'b0;
        tick();
        core_done = 1'b0;
        ended = 1'b0;
        for (int c = 1; c <= MAXC && !ended; c++) begin
            core_done = (c == done_at);
            abort     = (c == abort_at);
            start     = noisy ? 1'($urandom) : 1'b0;
            ack       = noisy ? 1'($urandom) : 1'b0;
            tick();
            idle_inputs();
            if (c == abort_at) begin
                chk_st("abort->idle", 4'b1000);
                chk_res("abort");
                ended = 1'b1;
            end else if (c == done_at || c == MAXC) begin
                exp_cc = c;
                exp_to = (c == done_at) ? 0 : 1;
                exp_rc = (exp_rc + 1) % (1 << RW);
                chk_st("fin", 4'b0001);
                chk_res("fin");
                ended = 1'b1;
                if (noisy) begin
                    for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                        start = 1'($urandom); abort = 1'($urandom);
                        core_done = 1'($urandom);
                        tick();
                        idle_inputs();
                        chk_st("fin hold", 4'b0001);
                        chk_res("fin hold");
                    end
                end
                ack = 1'b1; start = 1'b1; core_done = 1'b1;
                tick();
                ack = 1'b0; start = 1'b0;
                chk_st("ack->idle", 4'b1000);
                tick();
                core_done = 1'b0;
                chk_st("no relaunch", 4'b1000);
                chk_res("after ack");
            end else begin
                chk_st("run", 4'b0010);
            end
        end
        if (!ended) begin
            tests++; fails++;
            $display("FAIL run bound: no end of run within %0d cycles", MAXC);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        start = 1'b1;

        // Reset with start asserted
        tick(); tick();
        chk_st("reset st", 4'b1000);
        chk_res("reset");
        reset = 1'b1;
        start = 1'b0;

        //   st ab ak dn  state    to cc rc
        add(1, 0, 0, 0, 4'b1010, 0, 0, 0);
        add(0, 0, 0, 1, 4'b1010, 0, 0, 0);
        add(0, 0, 0, 1, 4'b0110, 0, 0, 0);
        add(0, 0, 0, 1, 4'b0010, 0, 0, 0);
        add(1, 0, 1, 0, 4'b0010, 0, 0, 0);
        add(0, 0, 0, 0, 4'b0010, 0, 0, 0);
        add(0, 0, 0, 1, 4'b0001, 0, 3, 1);
        add(1, 1, 0, 1, 4'b0001, 0, 3, 1);
        add(1, 0, 1, 1, 4'b1000, 0, 3, 1);
        add(0, 0, 0, 1, 4'b1000, 0, 3, 1);
        add(0, 1, 1, 0, 4'b1000, 0, 3, 1);
        add(1, 0, 0, 0, 4'b1010, 0, 3, 1);
        add(0, 0, 0, 0, 4'b1010, 0, 3, 1);
        add(0, 0, 0, 0, 4'b0110, 0, 3, 1);
        add(0, 1, 0, 1, 4'b1000, 0, 3, 1);
        add(1, 0, 0, 0, 4'b1010, 0, 3, 1);
        add(0, 1, 0, 0, 4'b1000, 0, 3, 1);
        add(0, 0, 0, 0, 4'b1000, 0, 3, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; abort = tbl[i].ab; ack = tbl[i].ak; core_done = tbl[i].dn;
            tick();
            chk($sformatf("vec%0d", i),
                32'({core_reset, core_req, busy, result_valid, timeout, cycle_count, run_count}),
                32'({tbl[i].es, tbl[i].eto, CW'(tbl[i].ecc), RW'(tbl[i].erc)}));
        end
        idle_inputs();
        exp_cc = 3; exp_to = 0; exp_rc = 1;

        do_run(10, 0, 1'b0);           // normal: done in RUN cycle 10
        do_run(0, 0, 1'b0);            // timeout at MAX
        do_run(MAXC, 0, 1'b0);         // done on the limit cycle wins
        do_run(0, 5, 1'b0);            // abort in RUN cycle 5
        do_run(7, 7, 1'b0);            // abort beats done
        do_run(MAXC, MAXC, 1'b0);      // abort beats done and limit

        for (int r = 0; r < 40; r++)
            do_run(int'($urandom_range(1, MAXC + 6)), int'($urandom_range(0, MAXC + 10)), 1'b1);

        // Reset in the middle of RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < RSTC + 4; k++) tick();
        chk_st("mid-run busy", 4'b0010);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_cc = 0; exp_to = 0; exp_rc = 0;
        chk_st("mid-run reset", 4'b1000);
        chk_res("mid-run reset");
        tick();
        chk_st("post reset idle", 4'b1000);

        // run_count wrap
        for (int r = 0; r < 255; r++) do_run(int'($urandom_range(1, 4)), 0, 1'b0);
        chk("run_count 255", 32'(run_count), 32'd255);
        do_run(2, 0, 1'b0);
        chk("run_count wrap", 32'(run_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
